// File: rtl/mem_pkg.sv
// Shared command, width and state definitions for the memory request servicer.
package mem_pkg;
  localparam int MEM_ADDR_W = 22;
  localparam int MEM_DATA_W = 64;

  typedef enum logic [1:0] {
    CMD_NOOP    = 2'd0,
    CMD_REFRESH = 2'd1,
    CMD_READ    = 2'd2,
    CMD_WRITE   = 2'd3
  } cmd_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mem_bram_array.sv
// Single-port write-first word array with a READ_LAT-deep registered read path.
// The clear port overrides the request port while the array is being zero-filled.
module mem_bram_array
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  clr_en,
  input  logic [ADDR_W-1:0]     clr_addr,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [MEM_DATA_W-1:0] wdata,
  output logic [MEM_DATA_W-1:0] rdata
);
  logic [MEM_DATA_W-1:0] mem [2**ADDR_W];
  logic [MEM_DATA_W-1:0] pipe [READ_LAT];
  logic                  wr;
  logic [ADDR_W-1:0]     wa;
  logic [MEM_DATA_W-1:0] wd;

  always_comb begin
    wr = clr_en || we;
    wa = clr_en ? clr_addr : addr;
    wd = clr_en ? '0 : wdata;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wa] <= wd;
    pipe[0] <= (wr && (wa == addr)) ? wd : mem[addr];
    for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[READ_LAT-1];
endmodule

// File: rtl/mem_req_servicer.sv
// Pops decoder memory commands, executes them against the word array and returns
// read data in issue order, throttled by outstanding reads and response backpressure.
//
// state | meaning
// INIT  | zero-filling the array one word per cycle, no pops
// RUN   | popping and servicing commands
module mem_req_servicer
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int READ_LAT     = 2,
  parameter int MAX_OUTST    = 4,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mem_req_rd_cmd,
  input  logic [MEM_ADDR_W-1:0] mem_req_rd_addr,
  input  logic [MEM_DATA_W-1:0] mem_req_rd_dta,
  output logic                  mem_req_rd_en,
  input  logic                  mem_req_rd_valid,
  output logic [MEM_DATA_W-1:0] mem_res_wr_dta,
  output logic                  mem_res_wr_en,
  input  logic                  mem_res_wr_almost_full,
  output logic                  init_done,
  output logic                  addr_error,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
);
  state_e                state;
  logic [ADDR_W-1:0]     clr_cnt;
  logic                  pop_q;
  logic [4:0]            outst;
  logic [4:0]            outst_nxt;
  logic [READ_LAT-1:0]   tag_v;
  logic [READ_LAT-1:0]   tag_err;
  logic                  take, is_rd, is_wr, bad, ret, arr_we, clr_en;
  logic [MEM_DATA_W-1:0] arr_rdata;

  always_comb begin
    take      = mem_req_rd_valid && pop_q;
    is_rd     = take && (cmd_e'(mem_req_rd_cmd) == CMD_READ);
    is_wr     = take && (cmd_e'(mem_req_rd_cmd) == CMD_WRITE);
    bad       = (mem_req_rd_addr >> ADDR_W) != '0;
    ret       = tag_v[READ_LAT-1];
    arr_we    = is_wr && !bad;
    clr_en    = (state == INIT);
    outst_nxt = outst + {4'd0, is_rd} - {4'd0, ret};
  end

  mem_bram_array #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) u_array (
    .clk      (clk),
    .clr_en   (clr_en),
    .clr_addr (clr_cnt),
    .we       (arr_we),
    .addr     (mem_req_rd_addr[ADDR_W-1:0]),
    .wdata    (mem_req_rd_dta),
    .rdata    (arr_rdata)
  );

  assign mem_res_wr_en  = ret;
  assign mem_res_wr_dta = (ret && !tag_err[READ_LAT-1]) ? arr_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST != 0) state <= INIT;
      else                   state <= RUN;
      clr_cnt       <= '0;
      init_done     <= 1'b0;
      mem_req_rd_en <= 1'b0;
      pop_q         <= 1'b0;
      outst         <= '0;
      tag_v         <= '0;
      tag_err       <= '0;
      addr_error    <= 1'b0;
      stat_reads    <= '0;
      stat_writes   <= '0;
    end else begin
      pop_q      <= mem_req_rd_en;
      tag_v[0]   <= is_rd;
      tag_err[0] <= bad;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_err[i] <= tag_err[i-1];
      end
      outst <= outst_nxt;
      if ((is_rd || is_wr) && bad) addr_error <= 1'b1;
      if (is_rd)  stat_reads  <= stat_reads + 32'd1;
      if (arr_we) stat_writes <= stat_writes + 32'd1;
      case (state)
        INIT: begin
          mem_req_rd_en <= 1'b0;
          clr_cnt       <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          init_done <= 1'b1;
          // a pop granted this cycle delivers next cycle, so reserve a slot for it
          mem_req_rd_en <= !mem_res_wr_almost_full &&
                           ((outst_nxt + {4'd0, mem_req_rd_en}) < 5'(MAX_OUTST));
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_servicer.sv
// Randomized self-checking bench: a FIFO-style request driver, a response monitor
// and a sequential array model that predicts every returned word and counter.
module tb_mem_req_servicer;
  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int MO  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic [21:0] addr = '0;
  logic [63:0] dta = '0;
  logic        valid = 1'b0;
  logic        af = 1'b0;
  logic        rd_en, res_en, init_done, addr_error;
  logic [63:0] res_dta;
  logic [31:0] stat_reads, stat_writes;

  always #5 clk = ~clk;

  mem_req_servicer #(.ADDR_W(AW), .READ_LAT(LAT), .MAX_OUTST(MO), .CLEAR_ON_RST(1)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .mem_req_rd_cmd         (cmd),
    .mem_req_rd_addr        (addr),
    .mem_req_rd_dta         (dta),
    .mem_req_rd_en          (rd_en),
    .mem_req_rd_valid       (valid),
    .mem_res_wr_dta         (res_dta),
    .mem_res_wr_en          (res_en),
    .mem_res_wr_almost_full (af),
    .init_done              (init_done),
    .addr_error             (addr_error),
    .stat_reads             (stat_reads),
    .stat_writes            (stat_writes)
  );

  typedef struct {
    logic [1:0]  c;
    logic [21:0] a;
    logic [63:0] d;
  } req_t;

  req_t        fifo_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          got_cyc[$];
  int          iss_cyc[$];
  logic [63:0] model_mem [16];
  int          exp_rd, exp_wr;
  logic        exp_err;
  int          cyc = 0, n_issued = 0, n_ret = 0, n_pulse = 0, max_infl = 0;
  bit          spurious = 0;
  int          checks = 0, passes = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // request FIFO: pops granted by rd_en present valid data on the following cycle
  initial begin
    bit   pop;
    req_t r;
    forever begin
      @(negedge clk);
      pop = (rd_en === 1'b1) && !rst;
      @(posedge clk);
      #1;
      if (pop && !rst && fifo_q.size() > 0) begin
        r = fifo_q.pop_front();
        cmd = r.c; addr = r.a; dta = r.d; valid = 1'b1;
        if (r.c == 2'd2) begin
          iss_cyc.push_back(cyc);
          n_issued++;
        end
      end else if (!pop && spurious && $urandom_range(0, 1) == 1) begin
        cmd = 2'd3; addr = 22'd1; dta = 64'hBAD0_BAD0_BAD0_BAD0; valid = 1'b1;
      end else begin
        valid = 1'b0; cmd = 2'($urandom); addr = 22'($urandom); dta = {$urandom, $urandom};
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (res_en === 1'b1) begin
      got_q.push_back(res_dta);
      got_cyc.push_back(cyc);
      n_ret++;
      n_pulse++;
    end
    if (n_issued - n_ret > max_infl) max_infl = n_issued - n_ret;
  end

  task automatic push_cmd(input logic [1:0] c, input logic [21:0] a, input logic [63:0] d);
    req_t r;
    r.c = c; r.a = a; r.d = d;
    fifo_q.push_back(r);
    if (c == 2'd3) begin
      if (a >= 22'd16) exp_err = 1'b1;
      else begin
        model_mem[a[3:0]] = d;
        exp_wr++;
      end
    end else if (c == 2'd2) begin
      exp_rd++;
      if (a >= 22'd16) begin
        exp_err = 1'b1;
        exp_q.push_back(64'h0);
      end else exp_q.push_back(model_mem[a[3:0]]);
    end
  endtask

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_cyc.delete(); iss_cyc.delete();
    n_issued = 0; n_ret = 0; max_infl = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 64'h0;
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0;
    fifo_q.delete();
    clear_q();
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && got_q.size() >= exp_q.size()) ok = 1'b1;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    bit seen_en = 0;
    rst = 1'b1; af = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, res_en, init_done, addr_error} !== 4'b0 || stat_reads !== 0 ||
        stat_writes !== 0 || res_dta !== 64'h0)
      $display("FAIL reset_outputs: got en=%b res=%b done=%b err=%b rd=%0d wr=%0d, want all 0",
               rd_en, res_en, init_done, addr_error, stat_reads, stat_writes);
    else passes++;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0) seen_en = 1;
      if (i == 15) begin
        checks++;
        if (init_done !== 1'b0) $display("FAIL init_done_early: got %b after 15 cycles, want 0", init_done);
        else passes++;
      end
      if (i == 16) begin
        checks++;
        if (init_done !== 1'b1) $display("FAIL init_done_rise: got %b after 16 cycles, want 1", init_done);
        else passes++;
      end
    end
    checks++;
    if (seen_en) $display("FAIL rd_en_during_init: got rd_en=1 during INIT, want 0");
    else passes++;
  endtask

  task automatic test_init_read();
    bit ok;
    push_cmd(2'd2, 22'd5, 64'h0);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != 1) $display("FAIL init_read_count: got %0d responses, want 1", got_q.size());
    else begin
      passes++;
      checks++;
      if (got_q[0] !== 64'h0) $display("FAIL init_read_data: got %h, want 0", got_q[0]);
      else passes++;
    end
    clear_q();
  endtask

  task automatic test_write_read();
    bit ok;
    push_cmd(2'd3, 22'd3, 64'hDEAD_BEEF_0123_4567);
    push_cmd(2'd2, 22'd3, 64'h0);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != 1) $display("FAIL wr_rd_count: got %0d responses, want 1", got_q.size());
    else begin
      passes++;
      checks++;
      if (got_q[0] !== 64'hDEAD_BEEF_0123_4567) $display("FAIL wr_rd_data: got %h, want deadbeef01234567", got_q[0]);
      else passes++;
      checks++;
      if (got_cyc[0] - iss_cyc[0] != LAT) $display("FAIL wr_rd_latency: got %0d, want %0d", got_cyc[0] - iss_cyc[0], LAT);
      else passes++;
    end
    checks++;
    if (stat_writes !== 32'(exp_wr) || stat_reads !== 32'(exp_rd))
      $display("FAIL wr_rd_stats: got rd=%0d wr=%0d, want rd=%0d wr=%0d", stat_reads, stat_writes, exp_rd, exp_wr);
    else passes++;
    clear_q();
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 16; i++) push_cmd(2'd3, 22'(i), {$urandom, $urandom});
    for (int i = 0; i < 8; i++) push_cmd(2'd2, 22'($urandom_range(0, 15)), 64'h0);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != 8) $display("FAIL b2b_count: got %0d responses, want 8", got_q.size());
    else begin
      passes++;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_cyc[i] - iss_cyc[i] != LAT)
          $display("FAIL b2b_resp%0d: got %h lat %0d, want %h lat %0d", i, got_q[i], got_cyc[i] - iss_cyc[i], exp_q[i], LAT);
        else passes++;
      end
    end
    checks++;
    if (max_infl > MO) $display("FAIL b2b_outstanding: got max %0d, want <= %0d", max_infl, MO);
    else passes++;
    clear_q();
  endtask

  task automatic test_backpressure();
    bit ok = 0, en_seen = 0;
    for (int i = 0; i < 12; i++) push_cmd(2'd2, 22'($urandom_range(0, 15)), 64'h0);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (n_issued - n_ret >= 2) ok = 1;
    end
    checks++;
    if (!ok) $display("FAIL bp_inflight: got %0d in flight, want 2", n_issued - n_ret);
    else passes++;
    af = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0) $display("FAIL bp_rd_en_drop: got %b, want 0", rd_en);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0) en_seen = 1;
    end
    checks++;
    if (en_seen || n_issued != n_ret)
      $display("FAIL bp_hold: got rd_en seen=%0d issued=%0d returned=%0d, want 0 and equal", en_seen, n_issued, n_ret);
    else passes++;
    af = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1) $display("FAIL bp_resume: got rd_en %b, want 1", rd_en);
    else passes++;
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != 12) $display("FAIL bp_count: got %0d responses, want 12", got_q.size());
    else begin
      passes++;
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL bp_resp%0d: got %h, want %h", i, got_q[i], exp_q[i]);
        else passes++;
      end
    end
    clear_q();
  endtask

  task automatic test_addr_error();
    bit ok;
    checks++;
    if (addr_error !== 1'b0) $display("FAIL err_clear: got %b, want 0", addr_error);
    else passes++;
    push_cmd(2'd3, 22'h3F_FFFF, {$urandom, $urandom});
    push_cmd(2'd2, 22'h3F_FFFF, 64'h0);
    push_cmd(2'd2, 22'd15, 64'h0);
    wait_drain(ok);
    checks++;
    if (addr_error !== 1'b1) $display("FAIL err_set: got %b, want 1", addr_error);
    else passes++;
    checks++;
    if (stat_writes !== 32'(exp_wr) || stat_reads !== 32'(exp_rd))
      $display("FAIL err_stats: got rd=%0d wr=%0d, want rd=%0d wr=%0d", stat_reads, stat_writes, exp_rd, exp_wr);
    else passes++;
    checks++;
    if (!ok || got_q.size() != 2) $display("FAIL err_count: got %0d responses, want 2", got_q.size());
    else begin
      passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) $display("FAIL err_resp%0d: got %h, want %h", i, got_q[i], exp_q[i]);
        else passes++;
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    bit ok = 0;
    int n;
    spurious = 1;
    for (int i = 0; i < 40; i++)
      push_cmd(2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 22'h20_0000 | 22'($urandom_range(0, 15)) : 22'($urandom_range(0, 15)),
               {$urandom, $urandom});
    push_cmd(2'd2, 22'd1, 64'h0);
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      af = ($urandom_range(0, 3) == 0);
      if (fifo_q.size() == 0 && got_q.size() >= exp_q.size()) ok = 1;
    end
    af = 1'b0;
    spurious = 0;
    wait_drain(ok);
    n = exp_q.size();
    checks++;
    if (!ok || got_q.size() != n) $display("FAIL rand_count: got %0d responses, want %0d", got_q.size(), n);
    else begin
      passes++;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_cyc[i] - iss_cyc[i] != LAT)
          $display("FAIL rand_resp%0d: got %h lat %0d, want %h lat %0d", i, got_q[i], got_cyc[i] - iss_cyc[i], exp_q[i], LAT);
        else passes++;
      end
    end
    checks++;
    if (stat_writes !== 32'(exp_wr) || stat_reads !== 32'(exp_rd) || addr_error !== exp_err || max_infl > MO)
      $display("FAIL rand_stats: got rd=%0d wr=%0d err=%b maxo=%0d, want rd=%0d wr=%0d err=%b maxo<=%0d",
               stat_reads, stat_writes, addr_error, max_infl, exp_rd, exp_wr, exp_err, MO);
    else passes++;
    clear_q();
  endtask

  task automatic test_reset_midop();
    bit ok = 0;
    int p0;
    for (int i = 0; i < 10; i++) push_cmd(2'd2, 22'($urandom_range(0, 15)), 64'h0);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (n_issued >= 3 && n_issued - n_ret >= 2) ok = 1;
    end
    checks++;
    if (!ok) $display("FAIL rst_mid_setup: got issued=%0d inflight=%0d, want >=3 and >=2", n_issued, n_issued - n_ret);
    else passes++;
    rst = 1'b1;
    @(posedge clk);
    #1 p0 = n_pulse;
    repeat (2) @(negedge clk);
    checks++;
    if (stat_reads !== 0 || stat_writes !== 0 || addr_error !== 1'b0 || init_done !== 1'b0)
      $display("FAIL rst_mid_clear: got rd=%0d wr=%0d err=%b done=%b, want all 0", stat_reads, stat_writes, addr_error, init_done);
    else passes++;
    rst = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    checks++;
    if (n_pulse != p0) $display("FAIL rst_mid_pulses: got %0d pushes after reset, want 0", n_pulse - p0);
    else passes++;
    checks++;
    if (init_done !== 1'b1) $display("FAIL rst_mid_reinit: got init_done %b, want 1", init_done);
    else passes++;
    push_cmd(2'd2, 22'd3, 64'h0);
    push_cmd(2'd2, 22'd9, 64'h0);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != 2) $display("FAIL rst_mid_count: got %0d responses, want 2", got_q.size());
    else begin
      passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || got_cyc[i] - iss_cyc[i] != LAT)
          $display("FAIL rst_mid_resp%0d: got %h lat %0d, want %h lat %0d", i, got_q[i], got_cyc[i] - iss_cyc[i], exp_q[i], LAT);
        else passes++;
      end
    end
    checks++;
    if (stat_reads !== 32'(exp_rd) || stat_writes !== 32'(exp_wr))
      $display("FAIL rst_mid_stats: got rd=%0d wr=%0d, want rd=%0d wr=%0d", stat_reads, stat_writes, exp_rd, exp_wr);
    else passes++;
    clear_q();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_read();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_addr_error();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
